// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
//   Memory-side responder for the core's load/store port. Word-addressed
//   32-bit RAM behind a req/ready handshake, with per-byte store enables,
//   a fixed number of wait states before good accesses complete, and a
//   fast error response for misaligned or out-of-range addresses.
//
// Parameters
//   ADDR_WIDTH  word-index bits; depth = 2**ADDR_WIDTH words
//   LATENCY     wait-state cycles before a good access completes (0..15)
//
// Ports
//   clk    in   1   clock, rising edge
//   reset  in   1   asynchronous, active-high reset
//   req    in   1   request valid, sampled only while idle
//   we     in   1   1 = store, 0 = load
//   addr   in   32  byte address
//   wdata  in   32  store data
//   be     in   4   store byte enables, be[i] covers wdata[8i+7:8i]
//   rdata  out  32  load data, held until the next good load completes
//   ready  out  1   one-cycle completion pulse
//   err    out  1   qualifies ready: access rejected
//   busy   out  1   high from acceptance until the ready cycle, inclusive
// ---------------------------------------------------------------------------
module data_mem_responder #(
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        busy
);

    localparam int         DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t                  state;
    logic [3:0]              cnt;
    logic                    lat_we;
    logic [ADDR_WIDTH-1:0]   lat_idx;
    logic [31:0]             lat_wdata;
    logic [3:0]              lat_be;

    logic [31:0]             mem [DEPTH];

    // Request decode on the live inputs (only meaningful while idle).
    logic                    accept;
    logic                    bad;
    logic [ADDR_WIDTH-1:0]   idx;

    assign accept = (state == IDLE) && req;
    assign bad    = (addr[1:0] != 2'b00) || ((addr >> (ADDR_WIDTH + 2)) != 32'd0);
    assign idx    = addr[ADDR_WIDTH+1:2];

    // The RAM access happens either on the acceptance edge itself (zero wait
    // states) or on the edge that ends the last wait cycle; pick live or
    // latched request fields accordingly. Gated by reset so that a request
    // seen while reset is held can never touch the array.
    logic                    access;
    logic                    acc_we;
    logic [ADDR_WIDTH-1:0]   acc_idx;
    logic [31:0]             acc_wdata;
    logic [3:0]              acc_be;

    assign access    = !reset &&
                       ((accept && !bad && (LATENCY == 0)) ||
                        ((state == WAIT) && (cnt == 4'd0)));
    assign acc_we    = (state == IDLE) ? we    : lat_we;
    assign acc_idx   = (state == IDLE) ? idx   : lat_idx;
    assign acc_wdata = (state == IDLE) ? wdata : lat_wdata;
    assign acc_be    = (state == IDLE) ? be    : lat_be;

    // NOTE: the RAM array has no reset branch; clearing a memory on reset
    // would force it out of block RAM into flops. Contents are undefined
    // until written.
    always_ff @(posedge clk) begin
        if (access && acc_we) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_be[i]) begin
                    mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

    // NOTE: all state updates use non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            lat_we    <= 1'b0;
            lat_idx   <= '0;
            lat_wdata <= 32'd0;
            lat_be    <= 4'd0;
            rdata     <= 32'd0;
            ready     <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            ready <= 1'b0;
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        lat_we    <= we;
                        lat_idx   <= idx;
                        lat_wdata <= wdata;
                        lat_be    <= be;
                        busy      <= 1'b1;
                        if (bad) begin
                            // Fast fail: no wait states, no RAM access.
                            state <= RESP;
                            ready <= 1'b1;
                            err   <= 1'b1;
                        end else if (LATENCY == 0) begin
                            state <= RESP;
                            ready <= 1'b1;
                            if (!we) begin
                                rdata <= mem[idx];
                            end
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state <= RESP;
                        ready <= 1'b1;
                        if (!lat_we) begin
                            rdata <= mem[lat_idx];
                        end
                    end
                end
                RESP: begin
                    // ready/err were raised on entry; requests here are ignored.
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_data_mem_responder
//   Directed bench for data_mem_responder. One instance uses the default
//   LATENCY=2, a second one uses LATENCY=0 (own req, shared data inputs).
//   Inputs change and outputs are sampled 1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        req0;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        ready;
    logic        err;
    logic        busy;
    logic [31:0] rdata0;
    logic        ready0;
    logic        err0;
    logic        busy0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_WIDTH(8), .LATENCY(2)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .be    (be),
        .rdata (rdata),
        .ready (ready),
        .err   (err),
        .busy  (busy)
    );

    data_mem_responder #(.ADDR_WIDTH(8), .LATENCY(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .req   (req0),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .be    (be),
        .rdata (rdata0),
        .ready (ready0),
        .err   (err0),
        .busy  (busy0)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request to the LATENCY=2 instance: pulse req, wait (bounded) for
    // ready, check latency/err, then step through RESP back to idle.
    task automatic xfer(input string tag, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b,
                        input logic exp_err, input int exp_lat);
        int lat;
        we    = w;
        addr  = a;
        wdata = d;
        be    = b;
        req   = 1'b1;
        tick();
        req = 1'b0;
        chk({tag, " busy@accept"}, 64'(busy), 64'd1);
        lat = 0;
        while (!ready && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, " err"}, 64'(err), 64'(exp_err));
        tick();
        chk({tag, " idle ready/err/busy"}, 64'({ready, err, busy}), 64'd0);
    endtask

    logic [31:0] hold_addr [11];
    logic [10:0] hold_ready;
    logic [31:0] hold_rdata [11];

    initial begin
        reset = 1'b1;
        req   = 1'b0;
        req0  = 1'b0;
        we    = 1'b0;
        addr  = 32'd0;
        wdata = 32'd0;
        be    = 4'd0;

        // 1: outputs stay cleared while reset is held, whatever req does.
        for (int i = 0; i < 5; i++) begin
            req  = 1'($urandom_range(0, 1));
            req0 = 1'($urandom_range(0, 1));
            we   = 1'($urandom_range(0, 1));
            addr = 32'h10;
            tick();
            chk("reset outputs", {rdata, ready, err, busy}, 64'd0);
        end
        req   = 1'b0;
        req0  = 1'b0;
        reset = 1'b0;
        tick();

        // 2: full-word store and load back, LATENCY=2.
        xfer("st 10", 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 1'b0, 2);
        xfer("ld 10", 1'b0, 32'h10, 32'h0, 4'b0000, 1'b0, 2);
        chk("ld 10 rdata", 64'(rdata), 64'hDEADBEEF);

        // 3: partial-byte store, then an all-disabled store.
        xfer("st be0010", 1'b1, 32'h10, 32'h11223344, 4'b0010, 1'b0, 2);
        xfer("ld be0010", 1'b0, 32'h10, 32'h0, 4'b0000, 1'b0, 2);
        chk("ld be0010 rdata", 64'(rdata), 64'hDEAD33EF);
        xfer("st be0000", 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 1'b0, 2);
        xfer("ld be0000", 1'b0, 32'h10, 32'h0, 4'b0000, 1'b0, 2);
        chk("ld be0000 rdata", 64'(rdata), 64'hDEAD33EF);

        // 4: misaligned load and out-of-range store fail fast; word 0 aliases
        // the out-of-range address and must stay untouched.
        xfer("st 00", 1'b1, 32'h0, 32'h12345678, 4'b1111, 1'b0, 2);
        xfer("ld 13 bad", 1'b0, 32'h13, 32'h0, 4'b0000, 1'b1, 0);
        chk("bad ld rdata held", 64'(rdata), 64'hDEAD33EF);
        xfer("st 400 bad", 1'b1, 32'h400, 32'hBADBAD00, 4'b1111, 1'b1, 0);
        xfer("ld 00", 1'b0, 32'h0, 32'h0, 4'b0000, 1'b0, 2);
        chk("ld 00 rdata", 64'(rdata), 64'h12345678);

        // 5a: req held high with addr changing every cycle. Accepts land on
        // edges 0, 4, 8; anything else would pick up the misaligned 0x13.
        for (int k = 0; k < 11; k++) begin
            hold_addr[k]  = 32'h13;
            hold_rdata[k] = 32'h0;
        end
        hold_addr[0]  = 32'h10;
        hold_addr[4]  = 32'h0;
        hold_addr[8]  = 32'h10;
        hold_ready    = 11'b100_0100_0100;
        hold_rdata[2] = 32'hDEAD33EF;
        hold_rdata[6] = 32'h12345678;
        hold_rdata[10] = 32'hDEAD33EF;
        we  = 1'b0;
        req = 1'b1;
        for (int k = 0; k < 11; k++) begin
            addr = hold_addr[k];
            tick();
            chk($sformatf("hold ready e%0d", k), 64'({ready, err}), 64'({hold_ready[k], 1'b0}));
            if (hold_ready[k]) begin
                chk($sformatf("hold rdata e%0d", k), 64'(rdata), 64'(hold_rdata[k]));
            end
        end
        req = 1'b0;
        tick();

        // 5b: LATENCY=0 instance completes in the cycle after acceptance.
        we    = 1'b1;
        addr  = 32'h8;
        wdata = 32'hA5A5A5A5;
        be    = 4'b1111;
        req0  = 1'b1;
        tick();
        req0 = 1'b0;
        chk("lat0 st ready/err/busy", 64'({ready0, err0, busy0}), 64'b101);
        tick();
        chk("lat0 st after", 64'({ready0, err0, busy0}), 64'd0);
        we   = 1'b0;
        req0 = 1'b1;
        tick();
        req0 = 1'b0;
        chk("lat0 ld ready", 64'(ready0), 64'd1);
        chk("lat0 ld rdata", 64'(rdata0), 64'hA5A5A5A5);
        tick();
        req0 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("lat0 hold e%0d", k), 64'(ready0), 64'((k % 2) == 0));
        end
        req0 = 1'b0;
        tick();

        // 6: reset during WAIT discards the pending store.
        xfer("st 20", 1'b1, 32'h20, 32'hCAFEF00D, 4'b1111, 1'b0, 2);
        we    = 1'b1;
        addr  = 32'h20;
        wdata = 32'h55AA55AA;
        be    = 4'b1111;
        req   = 1'b1;
        tick();
        req = 1'b0;
        chk("abort busy@accept", 64'(busy), 64'd1);
        tick();
        reset = 1'b1;
        #1;
        chk("abort in reset", 64'({ready, err, busy}), 64'd0);
        #2;
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("abort no ready c%0d", k), 64'({ready, busy}), 64'd0);
        end
        chk("abort rdata cleared", 64'(rdata), 64'd0);
        xfer("ld 20", 1'b0, 32'h20, 32'h0, 4'b0000, 1'b0, 2);
        chk("ld 20 rdata", 64'(rdata), 64'hCAFEF00D);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
